// File: rtl/vpu_sram_pkg.sv
// Shared types and default geometry for the VPU SRAM read crossbar.
package vpu_sram_pkg;

  localparam int unsigned DEF_READ_PORT_CNT  = 3;
  localparam int unsigned DEF_BANK_CNT       = 4;
  localparam int unsigned DEF_BANK_CNT_LG2   = 2;
  localparam int unsigned DEF_BANK_DEPTH_LG2 = 10;
  localparam int unsigned DEF_DATA_WIDTH     = 512;

  // Bank read latency in cycles; the return pipeline is built for exactly one.
  localparam int unsigned RD_LAT = 1;

  typedef enum logic [1:0] {
    PORT_IDLE = 2'd0,
    PORT_WAIT = 2'd1,
    PORT_OWN  = 2'd2
  } port_state_e;

endpackage

// File: rtl/vpu_rr_arbiter.sv
// P-way round-robin arbiter: first requester at or after ptr wins, one-hot grant.
module vpu_rr_arbiter #(
  parameter int unsigned P     = 3,
  parameter int unsigned PTR_W = (P > 1) ? $clog2(P) : 1
) (
  input  logic [P-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [P-1:0]     gnt_c,
  output logic [PTR_W-1:0] gnt_idx_c
);

  int unsigned idx;
  logic        found;

  always_comb begin
    gnt_c     = '0;
    gnt_idx_c = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < P; i++) begin
      idx = (32'(ptr) + i) % P;
      if (!found && req[PTR_W'(idx)]) begin
        found                = 1'b1;
        gnt_c[PTR_W'(idx)]   = 1'b1;
        gnt_idx_c            = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/vpu_sram_rd_xbar.sv
// Read crossbar: per-bank round-robin burst locking of VPU read ports onto
// single-port SRAM banks, with a one-cycle registered return path per port.
module vpu_sram_rd_xbar
  import vpu_sram_pkg::*;
#(
  parameter int unsigned SRAM_READ_PORT_CNT  = DEF_READ_PORT_CNT,
  parameter int unsigned SRAM_BANK_CNT       = DEF_BANK_CNT,
  parameter int unsigned SRAM_BANK_CNT_LG2   = DEF_BANK_CNT_LG2,
  parameter int unsigned SRAM_BANK_DEPTH_LG2 = DEF_BANK_DEPTH_LG2,
  parameter int unsigned SRAM_DATA_WIDTH     = DEF_DATA_WIDTH
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic [SRAM_READ_PORT_CNT-1:0]                   rreq_i,
  input  logic [SRAM_READ_PORT_CNT*SRAM_BANK_CNT_LG2-1:0] rid_i,
  input  logic [SRAM_READ_PORT_CNT*SRAM_BANK_DEPTH_LG2-1:0] raddr_i,
  input  logic [SRAM_READ_PORT_CNT-1:0]                   reb_i,
  input  logic [SRAM_READ_PORT_CNT-1:0]                   rlast_i,
  output logic [SRAM_READ_PORT_CNT-1:0]                   rack_o,
  output logic [SRAM_READ_PORT_CNT*SRAM_DATA_WIDTH-1:0]   rdata_o,
  output logic [SRAM_READ_PORT_CNT-1:0]                   rvalid_o,
  output logic [SRAM_BANK_CNT-1:0]                        bank_re_o,
  output logic [SRAM_BANK_CNT*SRAM_BANK_DEPTH_LG2-1:0]    bank_addr_o,
  input  logic [SRAM_BANK_CNT*SRAM_DATA_WIDTH-1:0]        bank_rdata_i
);

  localparam int unsigned P  = SRAM_READ_PORT_CNT;
  localparam int unsigned B  = SRAM_BANK_CNT;
  localparam int unsigned BW = SRAM_BANK_CNT_LG2;
  localparam int unsigned AW = SRAM_BANK_DEPTH_LG2;
  localparam int unsigned W  = SRAM_DATA_WIDTH;
  localparam int unsigned PW = (P > 1) ? $clog2(P) : 1;

  port_state_e          state_q [P];
  port_state_e          state_d [P];

  logic [B-1:0]           lock_q, lock_d;
  logic [B-1:0][PW-1:0]   owner_q, owner_d;
  logic [B-1:0][PW-1:0]   rr_ptr_q, rr_ptr_d;

  logic [P-1:0]           rack_q;
  logic [P-1:0]           rvalid_q;
  logic [P-1:0][BW-1:0]   rbank_q, rbank_d;
  logic [P-1:0][W-1:0]    rhold_q;
  logic [P-1:0][W-1:0]    rdata_sel_c;

  logic [B-1:0][P-1:0]    cand_c;
  logic [B-1:0][P-1:0]    gnt_c;
  logic [B-1:0][PW-1:0]   gnt_idx_c;
  logic [B-1:0]           bank_gnt_c;
  logic [P-1:0]           port_gnt_c;

  logic [P-1:0]           own_hit_c;
  logic [P-1:0][BW-1:0]   own_bank_c;
  logic [P-1:0]           accept_c;
  logic [B-1:0]           release_c;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] i);
    if (32'(i) >= P - 1) return '0;
    return i + PW'(1);
  endfunction

  // Candidates: requesting ports not yet owning, targeting an unlocked bank.
  always_comb begin
    cand_c = '0;
    for (int unsigned b = 0; b < B; b++) begin
      for (int unsigned p = 0; p < P; p++) begin
        cand_c[b][p] = rreq_i[p] && (state_q[p] != PORT_OWN) && !lock_q[b] &&
                       (rid_i[p*BW +: BW] == BW'(b));
      end
    end
  end

  for (genvar gb = 0; gb < B; gb++) begin : g_arb
    vpu_rr_arbiter #(
      .P    (P),
      .PTR_W(PW)
    ) u_arb (
      .req      (cand_c[gb]),
      .ptr      (rr_ptr_q[gb]),
      .gnt_c    (gnt_c[gb]),
      .gnt_idx_c(gnt_idx_c[gb])
    );
  end

  always_comb begin
    bank_gnt_c = '0;
    port_gnt_c = '0;
    for (int unsigned b = 0; b < B; b++) begin
      bank_gnt_c[b] = |gnt_c[b];
      port_gnt_c    = port_gnt_c | gnt_c[b];
    end
  end

  // Locked banks are steered by their owner's beat strobe and address.
  always_comb begin
    bank_re_o   = '0;
    bank_addr_o = '0;
    release_c   = '0;
    own_hit_c   = '0;
    own_bank_c  = '0;
    for (int unsigned b = 0; b < B; b++) begin
      for (int unsigned p = 0; p < P; p++) begin
        if (lock_q[b] && (owner_q[b] == PW'(p))) begin
          own_hit_c[p]               = 1'b1;
          own_bank_c[p]              = BW'(b);
          bank_re_o[b]               = reb_i[p];
          bank_addr_o[b*AW +: AW]    = raddr_i[p*AW +: AW];
          release_c[b]               = reb_i[p] & rlast_i[p];
        end
      end
    end
    accept_c = '0;
    for (int unsigned p = 0; p < P; p++) begin
      accept_c[p] = reb_i[p] && own_hit_c[p] && (state_q[p] == PORT_OWN);
    end
  end

  // Port FSM next state.
  always_comb begin
    for (int unsigned p = 0; p < P; p++) begin
      state_d[p] = state_q[p];
      case (state_q[p])
        PORT_IDLE, PORT_WAIT: begin
          if (port_gnt_c[p])  state_d[p] = PORT_OWN;
          else if (rreq_i[p]) state_d[p] = PORT_WAIT;
          else                state_d[p] = PORT_IDLE;
        end
        PORT_OWN: begin
          if (accept_c[p] && rlast_i[p]) state_d[p] = PORT_IDLE;
        end
        default: state_d[p] = PORT_IDLE;
      endcase
    end
  end

  // Bank lock, ownership and round-robin pointer updates.
  always_comb begin
    lock_d   = lock_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    for (int unsigned b = 0; b < B; b++) begin
      if (release_c[b]) lock_d[b] = 1'b0;
      if (bank_gnt_c[b]) begin
        lock_d[b]   = 1'b1;
        owner_d[b]  = gnt_idx_c[b];
        rr_ptr_d[b] = ptr_inc(gnt_idx_c[b]);
      end
    end
  end

  // Return data is selected by the bank captured with each beat.
  always_comb begin
    rdata_sel_c = '0;
    rdata_o     = '0;
    for (int unsigned p = 0; p < P; p++) begin
      rbank_d[p] = accept_c[p] ? own_bank_c[p] : rbank_q[p];
      for (int unsigned b = 0; b < B; b++) begin
        if (rbank_q[p] == BW'(b)) rdata_sel_c[p] = bank_rdata_i[b*W +: W];
      end
      rdata_o[p*W +: W] = rvalid_q[p] ? rdata_sel_c[p] : rhold_q[p];
    end
  end

  assign rack_o   = rack_q;
  assign rvalid_o = rvalid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned p = 0; p < P; p++) state_q[p] <= PORT_IDLE;
    end else begin
      for (int unsigned p = 0; p < P; p++) state_q[p] <= state_d[p];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q   <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      rack_q   <= '0;
      rvalid_q <= '0;
      rbank_q  <= '0;
      rhold_q  <= '0;
    end else begin
      lock_q   <= lock_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      rack_q   <= port_gnt_c;
      rvalid_q <= accept_c;
      rbank_q  <= rbank_d;
      for (int unsigned p = 0; p < P; p++) begin
        if (rvalid_q[p]) rhold_q[p] <= rdata_sel_c[p];
      end
    end
  end

endmodule

// File: tb/tb_vpu_sram_rd_xbar.sv
// Bench for vpu_sram_rd_xbar: directed scenarios with literal expectations plus
// randomized port traffic checked every cycle against a behavioural model.
module tb_vpu_sram_rd_xbar;

  localparam int unsigned P  = 3;
  localparam int unsigned B  = 4;
  localparam int unsigned BW = 2;
  localparam int unsigned AW = 10;
  localparam int unsigned W  = 512;

  logic               clk = 1'b0;
  logic               rst;
  logic [P-1:0]       rreq, reb, rlast;
  logic [P*BW-1:0]    rid;
  logic [P*AW-1:0]    raddr;
  logic [P-1:0]       rack, rvalid;
  logic [P*W-1:0]     rdata;
  logic [B-1:0]       bank_re;
  logic [B*AW-1:0]    bank_addr;
  logic [B*W-1:0]     bank_rdata;

  vpu_sram_rd_xbar dut (
    .clk         (clk),
    .rst         (rst),
    .rreq_i      (rreq),
    .rid_i       (rid),
    .raddr_i     (raddr),
    .reb_i       (reb),
    .rlast_i     (rlast),
    .rack_o      (rack),
    .rdata_o     (rdata),
    .rvalid_o    (rvalid),
    .bank_re_o   (bank_re),
    .bank_addr_o (bank_addr),
    .bank_rdata_i(bank_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit mdl_on   = 1'b0;

  logic [W-1:0]  bdata   [B];
  logic [W-1:0]  s_bdata [B];
  logic [P-1:0]  s_rack, s_rvalid;
  logic [B-1:0]  s_bre;
  logic [AW-1:0] s_baddr [B];
  logic [W-1:0]  s_rdata [P];

  // Model: which bank each port owns (-1 none), bank locks/owners/pointers,
  // and the one-cycle return pipeline.
  int           m_own   [P];
  int           m_rb    [P];
  int           m_lock  [B];
  int           m_owner [B];
  int           m_ptr   [B];
  logic [P-1:0] m_rack, m_rv;
  logic [W-1:0] m_hold  [P];

  int a_st [P];
  int a_left [P];

  task automatic cmpw(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
  endtask

  task automatic cmpn(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
  endtask

  function automatic logic [W-1:0] rnd_w();
    logic [W-1:0] v;
    for (int k = 0; k < int'(W / 32); k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_compare();
    logic [B-1:0] e_bre;
    logic [AW-1:0] e_addr;
    e_bre = '0;
    for (int b = 0; b < int'(B); b++) begin
      e_addr = '0;
      if (m_lock[b] != 0) begin
        e_bre[b] = reb[m_owner[b]];
        e_addr   = raddr[m_owner[b]*AW +: AW];
      end
      cmpn($sformatf("mdl_baddr%0d", b), 32'(s_baddr[b]), 32'(e_addr));
    end
    cmpn("mdl_bank_re", 32'(s_bre), 32'(e_bre));
    cmpn("mdl_rack", 32'(s_rack), 32'(m_rack));
    cmpn("mdl_rvalid", 32'(s_rvalid), 32'(m_rv));
    for (int p = 0; p < int'(P); p++)
      cmpw($sformatf("mdl_rdata%0d", p), s_rdata[p], m_rv[p] ? bdata[m_rb[p]] : m_hold[p]);
  endtask

  task automatic model_update();
    int           gw [B];
    logic [P-1:0] nrv, nrack;
    if (rst) begin
      for (int p = 0; p < int'(P); p++) begin
        m_own[p] = -1; m_rb[p] = 0; m_hold[p] = '0;
      end
      for (int b = 0; b < int'(B); b++) begin
        m_lock[b] = 0; m_owner[b] = 0; m_ptr[b] = 0;
      end
      m_rack = '0; m_rv = '0;
      return;
    end
    for (int p = 0; p < int'(P); p++) if (m_rv[p]) m_hold[p] = bdata[m_rb[p]];
    nrv = '0;
    for (int p = 0; p < int'(P); p++) begin
      if (m_own[p] >= 0 && reb[p]) begin
        nrv[p]  = 1'b1;
        m_rb[p] = m_own[p];
      end
    end
    for (int b = 0; b < int'(B); b++) begin
      gw[b] = -1;
      if (m_lock[b] == 0) begin
        for (int i = 0; i < int'(P); i++) begin
          int q;
          q = (m_ptr[b] + i) % int'(P);
          if (gw[b] < 0 && rreq[q] && m_own[q] < 0 && int'(rid[q*BW +: BW]) == b) gw[b] = q;
        end
      end
    end
    for (int p = 0; p < int'(P); p++) begin
      if (m_own[p] >= 0 && reb[p] && rlast[p]) begin
        m_lock[m_own[p]] = 0;
        m_own[p] = -1;
      end
    end
    nrack = '0;
    for (int b = 0; b < int'(B); b++) begin
      if (gw[b] >= 0) begin
        m_lock[b]     = 1;
        m_owner[b]    = gw[b];
        m_own[gw[b]]  = b;
        m_ptr[b]      = (gw[b] + 1) % int'(P);
        nrack[gw[b]]  = 1'b1;
      end
    end
    m_rv   = nrv;
    m_rack = nrack;
  endtask

  // One clock: fresh bank data, sample, compare with model, advance model.
  task automatic tick();
    for (int b = 0; b < int'(B); b++) begin
      bdata[b] = rnd_w();
      bank_rdata[b*W +: W] = bdata[b];
    end
    #2;
    s_rack = rack; s_rvalid = rvalid; s_bre = bank_re;
    for (int b = 0; b < int'(B); b++) begin
      s_baddr[b] = bank_addr[b*AW +: AW];
      s_bdata[b] = bdata[b];
    end
    for (int p = 0; p < int'(P); p++) s_rdata[p] = rdata[p*W +: W];
    if (mdl_on) model_compare();
    model_update();
    if (rst) mdl_on = 1'b1;
    @(negedge clk);
    cyc++;
  endtask

  task automatic drv(input int p, input bit rq, input int id, input bit e, input int a, input bit l);
    rreq[p] = rq;
    rid[p*BW +: BW] = BW'(id);
    reb[p] = e;
    raddr[p*AW +: AW] = AW'(a);
    rlast[p] = l;
  endtask

  task automatic clear_all();
    rreq = '0; reb = '0; rlast = '0; rid = '0; raddr = '0;
  endtask

  initial begin
    logic [W-1:0] keep;
    rst = 1'b1;
    clear_all();
    bank_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    cmpn("rst_rack", 32'(s_rack), 32'd0);
    cmpn("rst_rvalid", 32'(s_rvalid), 32'd0);
    cmpn("rst_bank_re", 32'(s_bre), 32'd0);
    cmpw("rst_rdata0", s_rdata[0], '0);

    // Single burst on bank 2
    drv(0, 1, 2, 0, 0, 0); tick();
    cmpn("sb_no_rack", 32'(s_rack), 32'd0);
    drv(0, 0, 2, 1, 5, 0); tick();
    cmpn("sb_rack", 32'(s_rack), 32'b001);
    cmpn("sb_re5", 32'(s_bre), 32'b0100);
    cmpn("sb_addr5", 32'(s_baddr[2]), 32'd5);
    drv(0, 0, 2, 1, 6, 0); tick();
    cmpn("sb_rv1", 32'(s_rvalid), 32'b001);
    cmpw("sb_data1", s_rdata[0], s_bdata[2]);
    cmpn("sb_addr6", 32'(s_baddr[2]), 32'd6);
    drv(0, 0, 2, 1, 7, 1); tick();
    cmpn("sb_rv2", 32'(s_rvalid), 32'b001);
    cmpn("sb_addr7", 32'(s_baddr[2]), 32'd7);
    drv(0, 0, 0, 0, 0, 0); tick();
    cmpn("sb_rv3", 32'(s_rvalid), 32'b001);
    cmpw("sb_data3", s_rdata[0], s_bdata[2]);
    cmpn("sb_re_off", 32'(s_bre), 32'd0);
    keep = s_bdata[2];
    tick();
    cmpn("sb_rv_off", 32'(s_rvalid), 32'd0);
    cmpw("sb_hold", s_rdata[0], keep);

    // Contention on bank 1, grant order 0,1,2 with two-cycle turnaround
    drv(0, 1, 1, 0, 0, 0); drv(1, 1, 1, 0, 0, 0); drv(2, 1, 1, 0, 0, 0); tick();
    cmpn("ct_none", 32'(s_rack), 32'd0);
    drv(0, 0, 1, 1, 10, 1); tick();
    cmpn("ct_rack0", 32'(s_rack), 32'b001);
    cmpn("ct_re0", 32'(s_bre), 32'b0010);
    drv(0, 0, 1, 0, 0, 0); tick();
    cmpn("ct_gap0", 32'(s_rack), 32'd0);
    cmpn("ct_rv0", 32'(s_rvalid), 32'b001);
    drv(1, 1, 1, 1, 11, 1); tick();
    cmpn("ct_rack1", 32'(s_rack), 32'b010);
    cmpn("ct_addr1", 32'(s_baddr[1]), 32'd11);
    drv(1, 0, 1, 0, 0, 0); tick();
    cmpn("ct_gap1", 32'(s_rack), 32'd0);
    cmpn("ct_rv1", 32'(s_rvalid), 32'b010);
    drv(2, 1, 1, 1, 12, 1); tick();
    cmpn("ct_rack2", 32'(s_rack), 32'b100);
    drv(2, 0, 1, 0, 0, 0); tick();
    // Pointer has wrapped to 0: port 0 beats port 2
    drv(0, 1, 1, 0, 0, 0); drv(2, 1, 1, 0, 0, 0); tick();
    drv(0, 0, 1, 1, 13, 1); tick();
    cmpn("ct_ptr_wrap", 32'(s_rack), 32'b001);
    drv(0, 0, 1, 0, 0, 0); tick();
    drv(2, 1, 1, 1, 14, 1); tick();
    cmpn("ct_rack2b", 32'(s_rack), 32'b100);
    drv(2, 0, 1, 0, 0, 0); tick();

    // Parallel bursts on banks 0 and 3
    drv(0, 1, 0, 0, 0, 0); drv(1, 1, 3, 0, 0, 0); tick();
    drv(0, 0, 0, 1, 20, 0); drv(1, 0, 3, 0, 0, 0); tick();
    cmpn("pa_rack", 32'(s_rack), 32'b011);
    cmpn("pa_re0", 32'(s_bre), 32'b0001);
    drv(0, 0, 0, 1, 21, 1); drv(1, 0, 3, 1, 30, 0); tick();
    cmpn("pa_re03", 32'(s_bre), 32'b1001);
    cmpn("pa_addr3", 32'(s_baddr[3]), 32'd30);
    cmpw("pa_d0a", s_rdata[0], s_bdata[0]);
    drv(0, 0, 0, 0, 0, 0); drv(1, 0, 3, 1, 31, 1); tick();
    cmpn("pa_rv", 32'(s_rvalid), 32'b011);
    cmpw("pa_d0b", s_rdata[0], s_bdata[0]);
    cmpw("pa_d1a", s_rdata[1], s_bdata[3]);
    drv(1, 0, 0, 0, 0, 0); tick();
    cmpw("pa_d1b", s_rdata[1], s_bdata[3]);

    // Beat strobe from an idle port is ignored
    drv(2, 0, 0, 1, 9, 0); tick();
    cmpn("il_re", 32'(s_bre), 32'd0);
    drv(2, 0, 0, 0, 0, 0); tick();
    cmpn("il_rv", 32'(s_rvalid), 32'd0);

    // Reset in the middle of a burst
    drv(0, 1, 2, 0, 0, 0); tick();
    drv(0, 0, 2, 1, 40, 0); tick();
    drv(0, 0, 2, 1, 41, 0); tick();
    rst = 1'b1; drv(0, 0, 2, 0, 0, 0); tick();
    rst = 1'b0; drv(0, 0, 2, 1, 42, 1); drv(1, 1, 2, 0, 0, 0); tick();
    cmpn("mr_rv", 32'(s_rvalid), 32'd0);
    cmpn("mr_rack", 32'(s_rack), 32'd0);
    cmpn("mr_re", 32'(s_bre), 32'd0);
    drv(0, 0, 0, 0, 0, 0); drv(1, 1, 2, 1, 50, 1); tick();
    cmpn("mr_regrant", 32'(s_rack), 32'b010);
    cmpn("mr_re2", 32'(s_bre), 32'b0100);
    drv(1, 0, 0, 0, 0, 0); tick();
    cmpn("mr_rv1", 32'(s_rvalid), 32'b010);

    // Randomized traffic
    rst = 1'b1; clear_all(); tick();
    rst = 1'b0;
    for (int p = 0; p < int'(P); p++) begin a_st[p] = 0; a_left[p] = 0; end
    for (int n = 0; n < 3000; n++) begin
      for (int p = 0; p < int'(P); p++) begin
        rreq[p] = 1'b0; reb[p] = 1'b0; rlast[p] = 1'b0;
        raddr[p*AW +: AW] = AW'($urandom);
        if (a_st[p] == 0) begin
          if ($urandom_range(3) == 0) begin
            a_st[p] = 1;
            a_left[p] = int'($urandom_range(1, 5));
            rid[p*BW +: BW] = BW'($urandom);
            rreq[p] = 1'b1;
          end else if ($urandom_range(15) == 0) begin
            reb[p] = 1'b1;
          end
        end else if (a_st[p] == 1) begin
          rreq[p] = 1'b1;
          if (rack[p]) a_st[p] = 2;
          else begin
            if ($urandom_range(15) == 0) rid[p*BW +: BW] = BW'($urandom);
            if ($urandom_range(15) == 0) reb[p] = 1'b1;
          end
        end
        if (a_st[p] == 2) begin
          if ($urandom_range(2) != 0) begin
            reb[p] = 1'b1;
            if (a_left[p] == 1) begin rlast[p] = 1'b1; a_st[p] = 0; end
            a_left[p]--;
          end else if ($urandom_range(7) == 0) begin
            rlast[p] = 1'b1;
          end
        end
      end
      tick();
    end
    clear_all();
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vpu_sram_rd_xbar.md
Name: vpu_sram_rd_xbar

Overview:
- SRAM-side read server that sits directly downstream of the VPU source-port interface (rreq/rid/raddr/reb/rlast -> rack/rdata/rvalid).
- Arbitrates SRAM_READ_PORT_CNT VPU read ports onto SRAM_BANK_CNT single-read-port banks. Arbitration is round-robin per bank.
- A grant locks the bank for the whole burst. The block returns read data to the owning port with fixed latency.

Parameters:
- SRAM_READ_PORT_CNT, 3, number of VPU read ports (P)
- SRAM_BANK_CNT, 4, number of SRAM banks (B)
- SRAM_BANK_CNT_LG2, 2, bank id width
- SRAM_BANK_DEPTH_LG2, 10, bank address width
- SRAM_DATA_WIDTH, 512, data width (W)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- rreq_i  in  P  per-port burst request, held until rack_o
- rid_i  in  P*SRAM_BANK_CNT_LG2  per-port target bank
- raddr_i  in  P*SRAM_BANK_DEPTH_LG2  per-port beat address
- reb_i  in  P  per-port read-beat strobe (active-high)
- rlast_i  in  P  marks final beat; qualified by reb_i
- rack_o  out  P  one-cycle grant pulse
- rdata_o  out  P*W  per-port read data
- rvalid_o  out  P  rdata_o valid
- bank_re_o  out  B  bank read enable
- bank_addr_o  out  B*SRAM_BANK_DEPTH_LG2  bank address
- bank_rdata_i  in  B*W  bank data, valid one cycle after bank_re_o

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset:
  - rack_o=0, rvalid_o=0, rdata_o=0, bank_re_o=0, bank_addr_o=0.
  - All bank locks cleared; all port FSMs go to IDLE; all RR pointers set to 0.
- Per-port FSM:
  - IDLE -> WAIT when rreq_i=1.
  - WAIT -> OWN at the edge where the port wins arbitration.
  - OWN -> IDLE at the edge where reb_i&rlast_i=1.
  - The WAIT state is combinational: arbitration considers any port in IDLE with rreq_i=1.
- Arbitration, per bank b, each cycle:
  - Candidates are ports not in OWN with rreq_i=1 and rid_i==b, and only while bank b is unlocked (registered lock state).
  - Winner is the first candidate at or after rr_ptr[b], wrapping modulo P.
  - At the edge: lock[b] set, owner[b]=winner, winner FSM -> OWN, rr_ptr[b] = winner+1 mod P, and rack_o[winner]=1 for exactly the next cycle.
- Different banks grant independently in the same cycle. A port can win at most one bank because it has a single rid.
- rreq_i is still high during the rack cycle; the port is in OWN, so no re-grant occurs.
- Beats:
  - Accepted only when the port is in OWN, including the rack cycle.
  - bank_re_o[owner]=reb_i[p] and bank_addr_o[owner]=raddr_i[p] combinationally, same cycle.
  - reb_i from a port not in OWN is ignored: no bank access, no rvalid.
- Return path:
  - rvalid_o[p] is registered, asserted exactly 1 cycle after an accepted beat.
  - rdata_o[p] = bank_rdata_i of the bank id captured with that beat. Use the captured id, not the current owner.
  - rdata_o holds its last value when rvalid_o=0.
  - Back-to-back beats produce back-to-back rvalid_o with no bubbles.
- Release:
  - reb_i&rlast_i clears lock[b] at the edge; the final beat's data still returns the next cycle.
  - The earliest re-grant decision for bank b is the cycle after release; its rack_o follows one cycle later (two-cycle bank turnaround).
  - rlast_i without reb_i is ignored.
- Throughput: 1 beat/cycle per bank; up to min(P,B) concurrent bursts.
- rid_i/raddr_i changes while in WAIT: the current value is used for arbitration.
- Reset mid-burst: locks and the return pipeline are flushed; an in-flight rvalid is dropped.
- No per-bank burst length limit; starvation is bounded by round-robin (max P-1 bursts ahead of any requester).

Decomposition:
- Shared package vpu_sram_pkg:
  - port FSM enum (IDLE/WAIT/OWN)
  - default widths and bank read latency constant RD_LAT=1
- Sub-module vpu_rr_arbiter:
  - parameterised P-way round-robin with pointer input and one-hot grant output
  - instantiated once per bank

Test Plan:
- Single burst: port0 rreq with rid=2, beats raddr 5,6,7 (rlast on 7) -> rack_o[0] 1 cycle after rreq; bank_re_o[2] with addr 5,6,7; rvalid_o[0] 3 consecutive cycles, each 1 cycle after its beat, with bank2 data.
- Contention: ports 0,1,2 request bank1 in the same cycle with rr_ptr=0 -> grant order 0,1,2; each next rack_o arrives 2 cycles after the previous owner's rlast; rr_ptr[1]=0 at end.
- Parallel: port0->bank0, port1->bank3 in the same cycle -> both rack_o in the same cycle; interleaved beats produce independent rvalid_o and no data crossover.
- Illegal beat: port2 pulses reb_i while IDLE, with addr 9 -> bank_re_o all 0, rvalid_o[2] stays 0.
- Release/re-grant: port0 rlast on bank1 at cycle t, port1 waiting -> rvalid_o[0] at t+1, rack_o[1] at t+2.
- Reset mid-burst: rst=1 between beats 2 and 3 -> next cycle all locks clear, rvalid_o=0, rack_o=0; a new request after reset is granted normally.
